// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - program counter, branch resolution and return-address stack
module branch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          RAS_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       isUBranch,
  input  logic                       isBeq,
  input  logic                       isBgt,
  input  logic                       isCall,
  input  logic                       isRet,
  input  logic                       isHalt,
  input  logic [26:0]                offset,
  input  logic                       Eq_flag,
  input  logic                       Gt_flag,
  output logic [31:0]                pc,
  output logic                       branch_taken,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_overflow,
  output logic                       ras_underflow,
  output logic                       halted
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {RUN, HALT} state_t;

  state_t        state;
  logic [31:0]   ras_mem [RAS_DEPTH];
  logic [PW-1:0] sp;        // next free slot; the top entry sits at sp-1
  logic [PW-1:0] top_idx;
  logic [31:0]   seq_pc;
  logic [31:0]   target;
  logic          ras_empty;
  logic          ras_full;
  logic          active;
  logic          push_en;

  // Next-address candidates and stack status for this cycle's decision
  always_comb begin
    seq_pc    = pc + 32'd4;
    target    = pc + {{3{offset[26]}}, offset, 2'b00};
    top_idx   = sp - 1'b1;
    ras_empty = (ras_count == '0);
    ras_full  = (ras_count == CW'(RAS_DEPTH));
    active    = (state == RUN) && !stall;
    push_en   = !reset && active && !isHalt && !isRet && isCall;
  end

  // Stack storage; a push onto a full stack lands on the oldest slot
  always_ff @(posedge clk) begin
    if (push_en) begin
      ras_mem[sp] <= seq_pc;
    end
  end

  // Control FSM: one prioritised action per unstalled RUN cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= RUN;
      pc            <= RESET_PC;
      branch_taken  <= 1'b0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
      halted        <= 1'b0;
      ras_count     <= '0;
      sp            <= '0;
    end else begin
      branch_taken  <= 1'b0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
      if (active) begin
        if (isHalt) begin
          state  <= HALT;
          halted <= 1'b1;
        end else if (isRet) begin
          if (!ras_empty) begin
            pc           <= ras_mem[top_idx];
            sp           <= top_idx;
            ras_count    <= ras_count - 1'b1;
            branch_taken <= 1'b1;
          end else begin
            pc            <= seq_pc;
            ras_underflow <= 1'b1;
          end
        end else if (isCall) begin
          pc           <= target;
          sp           <= sp + 1'b1;
          branch_taken <= 1'b1;
          if (ras_full) begin
            ras_overflow <= 1'b1;
          end else begin
            ras_count <= ras_count + 1'b1;
          end
        end else if (isUBranch) begin
          pc           <= target;
          branch_taken <= 1'b1;
        end else if (isBeq) begin
          pc           <= Eq_flag ? target : seq_pc;
          branch_taken <= Eq_flag;
        end else if (isBgt) begin
          pc           <= Gt_flag ? target : seq_pc;
          branch_taken <= Gt_flag;
        end else begin
          pc <= seq_pc;
        end
      end
    end
  end

endmodule
